// File: rtl/muldiv_pkg.sv
// Shared op and state encodings for the iterative multiply/divide unit.
package muldiv_pkg;

    localparam int unsigned XLEN_DEF  = 64;
    localparam int unsigned CNT_W_DEF = 7;

    typedef enum logic [1:0] {
        OP_MUL   = 2'b00,
        OP_MULHU = 2'b01,
        OP_DIVU  = 2'b10,
        OP_REMU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_e;

    function automatic logic is_div(input op_e op);
        return op[1];
    endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Shift-add multiplier / restoring divider sharing one hi/lo register pair.
module muldiv_datapath
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_load,
    input  logic            i_step,
    input  logic            i_finish,
    input  logic            i_dz,
    input  op_e             i_op,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic [XLEN-1:0] o_result
);

    op_e             r_op;
    logic [XLEN-1:0] r_hi;
    logic [XLEN-1:0] r_lo;
    logic [XLEN-1:0] r_b;
    logic [XLEN-1:0] r_result;

    logic [XLEN:0]   w_sum;
    logic [XLEN:0]   w_mul_acc;
    logic [XLEN:0]   w_rem_sh;
    logic [XLEN+1:0] w_diff;
    logic [XLEN+1:0] w_div_sel;
    logic            w_neg;
    logic [XLEN-1:0] w_nxt_hi;
    logic [XLEN-1:0] w_nxt_lo;
    logic [XLEN-1:0] w_final;

    // hi/lo hold product[2X-1:X]/product[X-1:0] when multiplying, rem/quo when dividing
    always_comb begin
        w_sum     = {1'b0, r_hi} + {1'b0, r_b};
        w_mul_acc = r_lo[0] ? w_sum : {1'b0, r_hi};
        w_rem_sh  = {r_hi, r_lo[XLEN-1]};
        w_diff    = {1'b0, w_rem_sh} - {2'b00, r_b};
        w_neg     = w_diff[XLEN+1];
        w_div_sel = w_neg ? {1'b0, w_rem_sh} : w_diff;
        if (is_div(r_op)) begin
            w_nxt_hi = XLEN'(w_div_sel);
            w_nxt_lo = {r_lo[XLEN-2:0], ~w_neg};
        end else begin
            w_nxt_hi = w_mul_acc[XLEN:1];
            w_nxt_lo = {w_mul_acc[0], r_lo[XLEN-1:1]};
        end
        // MUL/DIVU take the low half, MULHU/REMU the high half
        w_final = r_op[0] ? w_nxt_hi : w_nxt_lo;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op     <= OP_MUL;
            r_hi     <= '0;
            r_lo     <= '0;
            r_b      <= '0;
            r_result <= '0;
        end else begin
            if (i_load) begin
                r_op <= i_op;
                r_hi <= '0;
                r_lo <= is_div(i_op) ? i_a : i_b;
                r_b  <= is_div(i_op) ? i_b : i_a;
            end else if (i_step) begin
                r_hi <= w_nxt_hi;
                r_lo <= w_nxt_lo;
            end
            if (i_dz) begin
                r_result <= (i_op == OP_DIVU) ? '1 : i_a;
            end else if (i_finish) begin
                r_result <= w_final;
            end
        end
    end

    assign o_result = r_result;

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage M-extension unit: FSM, iteration counter and pipeline stall control.
module ex_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rd1,
    input  logic [XLEN-1:0] rd2,
    input  logic [4:0]      rd_in,
    input  logic            flush,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [4:0]       r_rd;
    logic [4:0]       r_rd_out;
    logic             w_load;
    logic             w_step;
    logic             w_finish;
    logic             w_dz;
    op_e              w_op;

    assign w_op = op_e'(op);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // next state and datapath strobes; flush beats start and aborts RUN/DONE
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        w_finish    = 1'b0;
        w_dz        = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start && !flush) begin
                    if (is_div(w_op) && (rd2 == '0)) begin
                        w_dz        = 1'b1;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_load      = 1'b1;
                        w_state_nxt = S_RUN;
                    end
                end
            end
            S_RUN: begin
                w_step = 1'b1;
                if (flush) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == CNT_LAST) begin
                    w_finish    = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_rd     <= '0;
            r_rd_out <= '0;
        end else begin
            if (w_load) begin
                r_cnt <= '0;
            end else if (w_step && (r_cnt != CNT_LAST)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_load) begin
                r_rd <= rd_in;
            end
            if (w_dz) begin
                r_rd_out <= rd_in;
            end else if (w_finish) begin
                r_rd_out <= r_rd;
            end
        end
    end

    muldiv_datapath #(
        .XLEN (XLEN)
    ) u_datapath (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_load),
        .i_step   (w_step),
        .i_finish (w_finish),
        .i_dz     (w_dz),
        .i_op     (w_op),
        .i_a      (rd1),
        .i_b      (rd2),
        .o_result (result)
    );

    assign stall  = ((r_state == S_IDLE) && start && !flush) || (r_state == S_RUN);
    assign busy   = (r_state != S_IDLE);
    assign done   = (r_state == S_DONE) && !flush;
    assign rd_out = r_rd_out;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: directed corner cases plus random ops.
module tb_ex_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [63:0] rd1;
    logic [63:0] rd2;
    logic [4:0]  rd_in;
    logic        flush;
    logic        stall;
    logic        busy;
    logic        done;
    logic [63:0] result;
    logic [4:0]  rd_out;

    typedef struct {
        logic [63:0] res;
        logic [4:0]  rd;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc   = 0;
    logic [63:0] last_res = '0;
    logic [4:0]  last_rd  = '0;

    ex_muldiv_unit dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .rd1    (rd1),
        .rd2    (rd2),
        .rd_in  (rd_in),
        .flush  (flush),
        .stall  (stall),
        .busy   (busy),
        .done   (done),
        .result (result),
        .rd_out (rd_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] model(input logic [1:0] o, input logic [63:0] a, input logic [63:0] b);
        logic [127:0] p;
        p = {64'd0, a} * {64'd0, b};
        case (o)
            2'd0:    return p[63:0];
            2'd1:    return p[127:64];
            2'd2:    return (b == 0) ? {64{1'b1}} : a / b;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // monitor: pop expectation on every done, check stall in steady cycles
    always @(negedge clk) begin
        if (!rst) begin
            if (done) begin
                if (q.size() == 0) begin
                    check("unexpected_done", 64'(done), 64'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("result", result, e.res);
                    check("rd_out", 64'(rd_out), 64'(e.rd));
                    check("done_cycle", 64'(cyc), 64'(e.cyc));
                    last_res = e.res;
                    last_rd  = e.rd;
                end
            end
            if (!start && !flush) begin
                check("stall", 64'(stall), 64'(busy && !done));
            end
        end
    end

    task automatic issue(input logic [1:0] o, input logic [63:0] a, input logic [63:0] b,
                         input logic [4:0] r, input bit expect_done);
        exp_t e;
        @(posedge clk);
        #1;
        start = 1'b1; op = o; rd1 = a; rd2 = b; rd_in = r;
        if (expect_done) begin
            e.res = model(o, a, b);
            e.rd  = r;
            e.cyc = cyc + ((o[1] && b == 0) ? 1 : 65);
            q.push_back(e);
        end
        #1;
        check("stall_on_start", 64'(stall), 64'd1);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (busy) check("idle_timeout", 64'(busy), 64'd0);
    endtask

    task automatic run_op(input logic [1:0] o, input logic [63:0] a, input logic [63:0] b, input logic [4:0] r);
        issue(o, a, b, r, 1'b1);
        wait_idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] a, b;
        logic [1:0]  o;
        rst = 1'b1; start = 1'b0; op = '0; rd1 = '0; rd2 = '0; rd_in = '0; flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_stall", 64'(stall), 64'd0);
        check("rst_result", result, 64'd0);
        check("rst_rd_out", 64'(rd_out), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        run_op(2'd0, 64'd3, 64'd5, 5'd7);
        run_op(2'd1, {64{1'b1}}, 64'd2, 5'd8);
        run_op(2'd0, {64{1'b1}}, 64'd2, 5'd9);
        run_op(2'd2, 64'd100, 64'd7, 5'd10);
        run_op(2'd3, 64'd100, 64'd7, 5'd11);
        run_op(2'd2, 64'd42, 64'd0, 5'd12);
        run_op(2'd3, 64'd42, 64'd0, 5'd0);

        // flush at cycle 10 of a divide: no done, result held
        issue(2'd2, 64'd1000, 64'd3, 5'd9, 1'b0);
        repeat (9) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_result", result, last_res);
        check("flush_rd_out", 64'(rd_out), 64'(last_rd));
        run_op(2'd0, 64'd6, 64'd7, 5'd3);

        // start at cycle 20 of a running op must be ignored
        issue(2'd0, 64'd11, 64'd13, 5'd4, 1'b1);
        repeat (19) begin @(posedge clk); #1; end
        start = 1'b1; op = 2'd2; rd1 = 64'd5; rd2 = 64'd0; rd_in = 5'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle();

        // async reset at cycle 30 of a run
        issue(2'd1, {$urandom, $urandom}, {$urandom, $urandom}, 5'd5, 1'b1);
        repeat (29) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_stall", 64'(stall), 64'd0);
        check("midrst_result", result, 64'd0);
        check("midrst_rd_out", 64'(rd_out), 64'd0);
        q.delete();
        last_res = '0;
        last_rd  = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 30; i++) begin
            o = 2'($urandom_range(0, 3));
            a = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0:       b = 64'd0;
                1:       b = 64'($urandom_range(1, 1000));
                2:       b = {$urandom, $urandom};
                default: b = a >> $urandom_range(0, 63);
            endcase
            run_op(o, a, b, 5'($urandom_range(0, 31)));
        end

        repeat (3) @(posedge clk);
        check("queue_drained", 64'(q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Execute-stage consumer of the ID/EX stage outputs for M-extension ops: MUL, MULHU, DIVU, REMU.
- Takes operands rd1/rd2, destination rd and a decoded op from the ID/EX stage.
- Computes the result iteratively, one bit per cycle, and asserts stall back to the hazard logic while busy.
- Presents the result plus rd to the EX/MEM stage with a one-cycle done pulse.

Parameters:
- XLEN, 64, operand and result width.
- CNT_W, 7, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  ID/EX holds a valid muldiv op this cycle.
- op  input  2  00 MUL (low XLEN), 01 MULHU (high XLEN), 10 DIVU, 11 REMU; all unsigned.
- rd1  input  XLEN  operand A (multiplicand / dividend).
- rd2  input  XLEN  operand B (multiplier / divisor).
- rd_in  input  5  destination register from ID/EX.
- flush  input  1  pipeline flush; aborts any op in progress.
- stall  output  1  freeze IF/ID and ID/EX.
- busy  output  1  state is not IDLE.
- done  output  1  one-cycle pulse: result valid.
- result  output  XLEN  computed value, held until the next accepted start.
- rd_out  output  5  rd captured at start, held with result.

Behaviour:
- Reset (async, rst=1): state=IDLE; busy=0, done=0, stall=0, result=0, rd_out=0; internal accumulators and counter cleared.
- States: IDLE, RUN, DONE.
- IDLE → RUN: start=1 and flush=0 at the edge.
  - Latch op, rd_in, rd1, rd2; clear counter.
  - Multiply: 2*XLEN product register = {0, rd2}.
  - Divide: remainder=0, quotient=rd1.
- IDLE → DONE (divide-by-zero fast path): start=1, op is DIVU/REMU, rd2=0.
  - DIVU result = all ones; REMU result = rd1; no iteration.
- RUN iteration, one per cycle, XLEN cycles:
  - MUL/MULHU: shift-add. If product LSB=1, add the multiplicand into the upper XLEN+1 bits, then shift right 1.
  - DIVU/REMU: restoring division. Shift {rem, quo} left 1, trial-subtract divisor from rem.
    - Non-negative: keep the difference, quo LSB=1.
    - Negative: restore, quo LSB=0.
- RUN → DONE when counter reaches XLEN-1.
  - Result registered: MUL = product[XLEN-1:0]; MULHU = product[2*XLEN-1:XLEN]; DIVU = quo; REMU = rem.
- DONE → IDLE unconditionally after one cycle. done=1 only in DONE.
- Latency from start edge to done high:
  - normal ops: XLEN+1 cycles (65 at default);
  - divide-by-zero: 1 cycle.
- stall (combinational):
  - high when (state==IDLE and start and not flush) or state==RUN;
  - low in DONE, so the pipeline advances in the same cycle the result is consumed.
- busy = (state != IDLE).
- start while RUN or DONE: ignored; no re-latch.
- flush has priority over start in IDLE.
- flush in RUN or DONE: next state IDLE, done suppressed, result/rd_out keep their previous values.
- rst asserted mid-operation: immediate return to reset values; no done.
- Counter saturates at XLEN-1; no wrap within an op.
- Arithmetic is unsigned only; the adder carry is kept in an XLEN+1 bit accumulator.
- rd_out=0 is passed through unchanged; suppressing writes to x0 is downstream's job.

Decomposition:
- Shared constants file muldiv_pkg holds:
  - op encodings OP_MUL, OP_MULHU, OP_DIVU, OP_REMU;
  - state encodings S_IDLE, S_RUN, S_DONE.
- Sub-module muldiv_datapath: holds the shift registers, adder/subtractor and result select, driven by load/step/finish strobes.
- ex_muldiv_unit keeps the FSM, counter and stall logic.

Test Plan:
- MUL rd1=3, rd2=5, rd_in=7 → stall high cycles 0..64, done at cycle 65, result=15, rd_out=7.
- MULHU rd1=0xFFFF_FFFF_FFFF_FFFF, rd2=2 → result=1 after 65 cycles; same operands with MUL → 0xFFFF_FFFF_FFFF_FFFE.
- DIVU 100/7 → result=14; REMU 100/7 → result=2; each done at cycle 65.
- DIVU rd1=42, rd2=0 → done at cycle 1, result=0xFFFF_FFFF_FFFF_FFFF; REMU 42/0 → result=42.
- Start DIVU, assert flush at cycle 10 → busy=0 at cycle 11, no done pulse, result unchanged; new MUL 6*7 then completes with result=42.
- Pulse start again at cycle 20 of a MUL → ignored, original result returned. Assert rst at cycle 30 of a run → all outputs 0 immediately, no done.
